qracc_vector_sequencer: RTL
===========================

# qracc_vector_sequencer

Parametrised sequencer between the activation buffer and `seq_acc`. For each of N input vectors it:
- fetches the vector from the activation buffer as a run of words;
- packs the words into one MAC operand and hands it to the accelerator under a valid/ready handshake;
- captures the accelerator result and writes it back to the buffer.

An accumulate mode sums results over all vectors, saturating, and writes a single output vector at the end.

## Interface
- `inputBits`, 4, bits per input element
- `inputElements`, 128, elements per input vector
- `outputBits`, 8, bits per output element, signed two's complement
- `outputElements`, 32, elements per output vector
- `bufWidth`, 32, buffer word width; must divide both `inputElements*inputBits` and `outputElements*outputBits`
- `addrWidth`, 32, buffer word-address width
- Derived: `IW = inputElements*inputBits/bufWidth` (16), `OW = outputElements*outputBits/bufWidth` (8)

Ports:
- `clk`  in  1  clock; everything is rising-edge.
- `nrst`  in  1  asynchronous, active-low reset.
- `start_i`  in  1  begin a job; the cfg inputs are sampled on this cycle.
- `clear_i`  in  1  synchronous abort back to IDLE.
- `cfg_num_vectors_i`  in  16  number of vectors N.
- `cfg_mode_i`  in  1  0 = per-vector output, 1 = accumulate.
- `cfg_in_base_i`  in  addrWidth  first input word address.
- `cfg_out_base_i`  in  addrWidth  first output word address.
- `busy_o`  out  1  high in any state other than IDLE.
- `done_o`  out  1  one-cycle completion pulse.
- `rd_en_o`  out  1  buffer read request.
- `rd_addr_o`  out  addrWidth  buffer read address.
- `rd_data_i`  in  bufWidth  read data, valid exactly one cycle after `rd_en_o`.
- `wr_en_o`  out  1  buffer write strobe.
- `wr_addr_o`  out  addrWidth  buffer write address.
- `wr_data_o`  out  bufWidth  buffer write data.
- `mac_data_o`  out  inputElements*inputBits  packed operand to the accelerator.
- `mac_valid_o`  out  1  operand valid.
- `acc_ready_i`  in  1  accelerator ready to accept an operand.
- `acc_valid_i`  in  1  accelerator result valid.
- `acc_data_i`  in  outputElements*outputBits  accelerator result.

## Operation
- States: IDLE, LOAD, FIRE, WAIT, STORE, DONE. The vector counter is `v`, running 0..N-1.
- IDLE:
  - On `start_i`, latch the cfg inputs and clear `v`.
  - If N=0, go to DONE; otherwise go to LOAD.
  - `start_i` is ignored in every non-IDLE state.
- LOAD (IW+1 cycles):
  - On LOAD cycle k (k = 0..IW-1), assert `rd_en_o` with `rd_addr_o = in_base + v*IW + k`.
  - On cycle k+1, capture `rd_data_i` into `mac_data` bits `[k*bufWidth +: bufWidth]`.
  - Cycle IW performs the last capture with `rd_en_o` low, then the FSM goes to FIRE.
- FIRE:
  - `mac_valid_o` is high and `mac_data_o` stays stable until a cycle with `acc_ready_i` high. That cycle is the transfer; go to WAIT.
- WAIT:
  - On the first cycle with `acc_valid_i` high, capture the result.
  - `acc_valid_i` is ignored in every other state.
  - Mode 0: load the result register, then go to STORE.
  - Mode 1, v=0: load the accumulator. Mode 1, v>0: add each element to the accumulator as a signed `outputBits` value, saturating to [-2^(outputBits-1), 2^(outputBits-1)-1].
  - Mode 1, after the capture: if v=N-1 go to STORE, otherwise increment `v` and go to LOAD.
- STORE (OW cycles):
  - On cycle j, assert `wr_en_o` with `wr_data_o` = result bits `[j*bufWidth +: bufWidth]`.
  - Write address: mode 0 uses `wr_addr_o = out_base + v*OW + j`; mode 1 uses `out_base + j`.
  - Exit: if v=N-1 go to DONE; otherwise increment `v` and go to LOAD. In mode 1 STORE is only ever reached with v=N-1.
- DONE: `done_o` is high for one cycle, then the FSM goes to IDLE.
- `clear_i` in any state:
  - Next state is IDLE with `rd_en_o`, `wr_en_o`, `mac_valid_o` and `busy_o` low.
  - No `done_o` pulse; any partial accumulation is discarded.
  - `clear_i` takes priority over `start_i`.
- Address arithmetic wraps modulo 2^addrWidth.

## Timing
- Reset values: all outputs 0, including `mac_data_o`, `rd_addr_o`, `wr_addr_o`, `wr_data_o`. State = IDLE, all counters and accumulator 0.
- Reset asserted mid-job: immediate return to reset values; nothing is written after reset assertion.
- All outputs are registered.
- `busy_o` rises the cycle after `start_i`.
- First `rd_en_o` is on the cycle after `start_i`.
- `mac_valid_o` first rises IW+1 cycles after LOAD entry.
- STORE starts the cycle after the `acc_valid_i` capture.
- `done_o` is asserted on the cycle after the final STORE write; `busy_o` falls the cycle after `done_o`.
- With N=0: `done_o` on the cycle after `start_i`, and no reads or writes occur.
- Vector throughput, mode 0, zero stall, 1-cycle accelerator latency: IW+1 (LOAD) + 1 (FIRE) + 1 (WAIT) + OW (STORE) = 27 cycles with defaults.

## Test plan
- **Mode 0, single vector, acc_ready=1, accelerator latency 3, in_base=0x100, out_base=0x200:**
  - Exactly 16 reads at 0x100..0x10F.
  - `mac_data_o` equals the concatenation with word 0 in the LSBs.
  - 8 writes at 0x200..0x207 carrying the result slices.
  - One `done_o` pulse.
- **Mode 0, N=3, `acc_ready_i` held low 5 cycles on vector 1:**
  - `mac_valid_o` stays high and `mac_data_o` stays bit-stable throughout the stall.
  - Vector 2 reads at in_base+32..+47; writes at out_base+16..+23.
- **Mode 1, N=2:**
  - Element results 100 and 100 -> written 127; -100 and -100 -> -128; 5 and -7 -> -2.
  - Only 8 writes total, at out_base+0..+7.
- **N=0:** `done_o` on the cycle after `start_i`; `rd_en_o`, `wr_en_o` and `mac_valid_o` never asserted.
- **Abort and reset:**
  - `clear_i` during WAIT -> IDLE next cycle, no writes, no `done_o`.
  - `nrst` low mid-STORE -> `wr_en_o` drops immediately, outputs at reset values.
  - A new `start_i` after either runs a clean job.
- **`start_i` pulsed while busy with different cfg:** ignored; the running job completes with its original addresses and N.

Source files
------------

// File: rtl/qracc_vector_sequencer.sv
// Vector sequencer: streams N activation vectors from the buffer into seq_acc and
// writes each result back, or a saturating element-wise sum of all results in accumulate mode.
module qracc_vector_sequencer #(
  parameter int inputBits      = 4,
  parameter int inputElements  = 128,
  parameter int outputBits     = 8,
  parameter int outputElements = 32,
  parameter int bufWidth       = 32,
  parameter int addrWidth      = 32
) (
  input  logic                                 clk,
  input  logic                                 nrst,
  input  logic                                 start_i,
  input  logic                                 clear_i,
  input  logic [15:0]                          cfg_num_vectors_i,
  input  logic                                 cfg_mode_i,
  input  logic [addrWidth-1:0]                 cfg_in_base_i,
  input  logic [addrWidth-1:0]                 cfg_out_base_i,
  output logic                                 busy_o,
  output logic                                 done_o,
  output logic                                 rd_en_o,
  output logic [addrWidth-1:0]                 rd_addr_o,
  input  logic [bufWidth-1:0]                  rd_data_i,
  output logic                                 wr_en_o,
  output logic [addrWidth-1:0]                 wr_addr_o,
  output logic [bufWidth-1:0]                  wr_data_o,
  output logic [inputElements*inputBits-1:0]   mac_data_o,
  output logic                                 mac_valid_o,
  input  logic                                 acc_ready_i,
  input  logic                                 acc_valid_i,
  input  logic [outputElements*outputBits-1:0] acc_data_i
);

  localparam int IN_W  = inputElements * inputBits;
  localparam int OUT_W = outputElements * outputBits;
  localparam int IW    = IN_W / bufWidth;
  localparam int OW    = OUT_W / bufWidth;
  localparam int KW    = $clog2(IW + 1);
  localparam int JW    = $clog2(OW + 1);

  localparam logic [KW-1:0]         K_LAST    = KW'(IW);
  localparam logic [KW-1:0]         K_LAST_RD = KW'(IW - 1);
  localparam logic [JW-1:0]         J_LAST    = JW'(OW - 1);
  localparam logic [addrWidth-1:0]  IW_A      = addrWidth'(IW);
  localparam logic [addrWidth-1:0]  OW_A      = addrWidth'(OW);
  localparam logic [outputBits-1:0] SAT_MAX   = {1'b0, {(outputBits-1){1'b1}}};
  localparam logic [outputBits-1:0] SAT_MIN   = {1'b1, {(outputBits-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_FIRE  = 3'd2,
    S_WAIT  = 3'd3,
    S_STORE = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t                r_state, w_state_next;
  logic [KW-1:0]         r_k, w_k_next;
  logic [JW-1:0]         r_j, w_j_next;
  logic [15:0]           r_v, w_v_next;
  logic [15:0]           r_num, w_num_next;
  logic                  r_mode, w_mode_next;
  logic [addrWidth-1:0]  r_vec_in, w_vec_in_next;
  logic [addrWidth-1:0]  r_vec_out, w_vec_out_next;
  logic [OUT_W-1:0]      r_result, w_result_next;
  logic [IN_W-1:0]       r_mac_data, w_mac_data_next;
  logic                  r_mac_valid, w_mac_valid_next;
  logic                  r_rd_en, w_rd_en_next;
  logic [addrWidth-1:0]  r_rd_addr, w_rd_addr_next;
  logic                  r_wr_en, w_wr_en_next;
  logic [addrWidth-1:0]  r_wr_addr, w_wr_addr_next;
  logic [bufWidth-1:0]   r_wr_data, w_wr_data_next;
  logic                  r_done, w_done_next;
  logic                  r_busy, w_busy_next;

  logic [OUT_W-1:0]      w_acc_sum;
  logic [OUT_W-1:0]      w_capture;
  logic                  w_last_vec;

  // Per-element signed add, one bit wider so overflow shows up as a sign disagreement
  for (genvar gi = 0; gi < outputElements; gi++) begin : g_sat
    logic [outputBits-1:0] w_a;
    logic [outputBits-1:0] w_b;
    logic [outputBits:0]   w_sum;
    assign w_a   = r_result[gi*outputBits +: outputBits];
    assign w_b   = acc_data_i[gi*outputBits +: outputBits];
    assign w_sum = {w_a[outputBits-1], w_a} + {w_b[outputBits-1], w_b};
    assign w_acc_sum[gi*outputBits +: outputBits] =
      (w_sum[outputBits] == w_sum[outputBits-1]) ? w_sum[outputBits-1:0] :
      (w_sum[outputBits] ? SAT_MIN : SAT_MAX);
  end

  assign w_capture  = (r_mode && (r_v != 16'd0)) ? w_acc_sum : acc_data_i;
  assign w_last_vec = (r_v == (r_num - 16'd1));

  always_comb begin
    w_state_next     = r_state;
    w_k_next         = r_k;
    w_j_next         = r_j;
    w_v_next         = r_v;
    w_num_next       = r_num;
    w_mode_next      = r_mode;
    w_vec_in_next    = r_vec_in;
    w_vec_out_next   = r_vec_out;
    w_result_next    = r_result;
    w_mac_data_next  = r_mac_data;
    w_mac_valid_next = r_mac_valid;
    w_rd_en_next     = r_rd_en;
    w_rd_addr_next   = r_rd_addr;
    w_wr_en_next     = r_wr_en;
    w_wr_addr_next   = r_wr_addr;
    w_wr_data_next   = r_wr_data;
    w_done_next      = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start_i) begin
          w_num_next     = cfg_num_vectors_i;
          w_mode_next    = cfg_mode_i;
          w_v_next       = 16'd0;
          w_vec_in_next  = cfg_in_base_i;
          w_vec_out_next = cfg_out_base_i;
          if (cfg_num_vectors_i == 16'd0) begin
            w_state_next = S_DONE;
            w_done_next  = 1'b1;
          end else begin
            w_state_next   = S_LOAD;
            w_k_next       = '0;
            w_rd_en_next   = 1'b1;
            w_rd_addr_next = cfg_in_base_i;
          end
        end
      end

      S_LOAD: begin
        // Data for the read issued in LOAD cycle k arrives during cycle k+1
        for (int i = 0; i < IW; i++) begin
          if (r_k == KW'(i + 1)) w_mac_data_next[i*bufWidth +: bufWidth] = rd_data_i;
        end
        if (r_k == K_LAST) begin
          w_state_next     = S_FIRE;
          w_mac_valid_next = 1'b1;
        end else begin
          w_k_next     = r_k + KW'(1);
          w_rd_en_next = (r_k < K_LAST_RD);
          if (r_k < K_LAST_RD) w_rd_addr_next = r_rd_addr + addrWidth'(1);
        end
      end

      S_FIRE: begin
        if (acc_ready_i) begin
          w_state_next     = S_WAIT;
          w_mac_valid_next = 1'b0;
        end
      end

      S_WAIT: begin
        if (acc_valid_i) begin
          w_result_next = w_capture;
          if (!r_mode || w_last_vec) begin
            w_state_next   = S_STORE;
            w_j_next       = '0;
            w_wr_en_next   = 1'b1;
            w_wr_addr_next = r_vec_out;
            w_wr_data_next = w_capture[bufWidth-1:0];
          end else begin
            w_state_next   = S_LOAD;
            w_v_next       = r_v + 16'd1;
            w_vec_in_next  = r_vec_in + IW_A;
            w_k_next       = '0;
            w_rd_en_next   = 1'b1;
            w_rd_addr_next = r_vec_in + IW_A;
          end
        end
      end

      S_STORE: begin
        if (r_j == J_LAST) begin
          w_wr_en_next = 1'b0;
          if (w_last_vec) begin
            w_state_next = S_DONE;
            w_done_next  = 1'b1;
          end else begin
            w_state_next   = S_LOAD;
            w_v_next       = r_v + 16'd1;
            w_vec_in_next  = r_vec_in + IW_A;
            w_vec_out_next = r_vec_out + OW_A;
            w_k_next       = '0;
            w_rd_en_next   = 1'b1;
            w_rd_addr_next = r_vec_in + IW_A;
          end
        end else begin
          w_j_next       = r_j + JW'(1);
          w_wr_addr_next = r_wr_addr + addrWidth'(1);
          for (int i = 1; i < OW; i++) begin
            if (r_j == JW'(i - 1)) w_wr_data_next = r_result[i*bufWidth +: bufWidth];
          end
        end
      end

      S_DONE: begin
        w_state_next = S_IDLE;
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase

    // Abort wins over everything, including a start in the same cycle
    if (clear_i) begin
      w_state_next     = S_IDLE;
      w_rd_en_next     = 1'b0;
      w_wr_en_next     = 1'b0;
      w_mac_valid_next = 1'b0;
      w_done_next      = 1'b0;
      w_result_next    = '0;
    end

    w_busy_next = (w_state_next != S_IDLE);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state     <= S_IDLE;
      r_k         <= '0;
      r_j         <= '0;
      r_v         <= '0;
      r_num       <= '0;
      r_mode      <= 1'b0;
      r_vec_in    <= '0;
      r_vec_out   <= '0;
      r_result    <= '0;
      r_mac_data  <= '0;
      r_mac_valid <= 1'b0;
      r_rd_en     <= 1'b0;
      r_rd_addr   <= '0;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_k         <= w_k_next;
      r_j         <= w_j_next;
      r_v         <= w_v_next;
      r_num       <= w_num_next;
      r_mode      <= w_mode_next;
      r_vec_in    <= w_vec_in_next;
      r_vec_out   <= w_vec_out_next;
      r_result    <= w_result_next;
      r_mac_data  <= w_mac_data_next;
      r_mac_valid <= w_mac_valid_next;
      r_rd_en     <= w_rd_en_next;
      r_rd_addr   <= w_rd_addr_next;
      r_wr_en     <= w_wr_en_next;
      r_wr_addr   <= w_wr_addr_next;
      r_wr_data   <= w_wr_data_next;
      r_done      <= w_done_next;
      r_busy      <= w_busy_next;
    end
  end

  assign busy_o      = r_busy;
  assign done_o      = r_done;
  assign rd_en_o     = r_rd_en;
  assign rd_addr_o   = r_rd_addr;
  assign wr_en_o     = r_wr_en;
  assign wr_addr_o   = r_wr_addr;
  assign wr_data_o   = r_wr_data;
  assign mac_data_o  = r_mac_data;
  assign mac_valid_o = r_mac_valid;

endmodule
